mult6bit_seq_ctrl: RTL and testbench



---
 rtl/mult_ctrl_pkg.sv | 49 ++++
 rtl/mult3bit.sv | 16 +
 rtl/mult6bit_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mult6bit_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
// Shared types and constants for the sequential 6x6 multiplier controller.
//   state_t      : controller states IDLE / CALC / DONE
//   OP_W/HALF_W  : operand width and half-operand width
//   RES_W        : product / accumulator width
//   STEP_*       : step counter values selecting each partial product
//   step_shift() : left-shift applied to the partial product of a step
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

    localparam int OP_W   = 6;
    localparam int HALF_W = 3;
    localparam int RES_W  = 12;
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Partial-product order: lo*lo, lo*hi, hi*lo, hi*hi (a first, b second).
    localparam logic [STEP_W-1:0] STEP_LL    = 3'd0;
    localparam logic [STEP_W-1:0] STEP_LH    = 3'd1;
    localparam logic [STEP_W-1:0] STEP_HL    = 3'd2;
    localparam logic [STEP_W-1:0] STEP_HH    = 3'd3;
    // Extra step used only when the multiplier output is registered: it
    // accumulates the last partial product still held in the pipe register.
    localparam logic [STEP_W-1:0] STEP_DRAIN = 3'd4;

    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd3;
    localparam logic [3:0] SHIFT_HL = 4'd3;
    localparam logic [3:0] SHIFT_HH = 4'd6;

    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        sh = SHIFT_LL;
        case (step)
            STEP_LH: sh = SHIFT_LH;
            STEP_HL: sh = SHIFT_HL;
            STEP_HH: sh = SHIFT_HH;
            default: sh = SHIFT_LL;
        endcase
        return sh;
    endfunction

endpackage : mult_ctrl_pkg

// File: rtl/mult3bit.sv
// -----------------------------------------------------------------------------
// mult3bit
// Combinational 3x3-bit unsigned multiplier.
//   a : input  [2:0]  multiplicand
//   b : input  [2:0]  multiplier
//   p : output [5:0]  a*b
// -----------------------------------------------------------------------------
module mult3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);

    assign p = {3'b000, a} * {3'b000, b};

endmodule : mult3bit

// File: rtl/mult6bit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult6bit_seq_ctrl
// Computes a 6x6-bit unsigned product by pushing four 3x3 partial products
// through a single shared mult3bit, shifting and accumulating them into a
// 12-bit result. Valid/ready handshake on both sides.
//
// Parameters:
//   PIPE_MUL : 1 = register the multiplier output before accumulation
//              (one extra cycle of latency); 0 = accumulate in the same cycle.
// Optional feature (compile-time macro MULT_CTRL_ZERO_SKIP_EN):
//   when defined, a zero operand at accept jumps straight to DONE with
//   result 0; otherwise zero operands take the normal four-step path.
//
// Ports:
//   clk       : in   system clock, rising edge
//   rst_n     : in   asynchronous reset, active low
//   in_valid  : in   operands valid
//   in_ready  : out  operands can be accepted (IDLE only)
//   num1      : in   [5:0] multiplicand
//   num2      : in   [5:0] multiplier
//   out_valid : out  result valid, held until accepted
//   out_ready : in   consumer accepts result
//   result    : out  [11:0] num1*num2
//   busy      : out  high in CALC or DONE
// -----------------------------------------------------------------------------
module mult6bit_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int PIPE_MUL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  num1,
    input  logic [OP_W-1:0]  num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             busy
);

    // With a registered multiplier the counter runs one step further to
    // drain the pipe register into the accumulator.
    localparam logic [STEP_W-1:0] LAST_STEP = (PIPE_MUL != 0) ? STEP_DRAIN : STEP_HH;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q;
    logic [OP_W-1:0]     a_q, b_q;
    logic [RES_W-1:0]    acc_q;
    logic [RES_W-1:0]    result_q;

    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [2*HALF_W-1:0] pp;
    logic [RES_W-1:0]    pp_shifted;
    logic [RES_W-1:0]    acc_add;
    logic [RES_W-1:0]    acc_sum;
    logic                zero_op;

`ifdef MULT_CTRL_ZERO_SKIP_EN
    assign zero_op = (num1 == '0) || (num2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Step-indexed operand mux feeding the single shared multiplier.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[HALF_W-1:0];
        case (step_q)
            STEP_LH: mul_b = b_q[OP_W-1:HALF_W];
            STEP_HL: mul_a = a_q[OP_W-1:HALF_W];
            STEP_HH: begin
                mul_a = a_q[OP_W-1:HALF_W];
                mul_b = b_q[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    mult3bit u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    assign pp_shifted = RES_W'(pp) << step_shift(step_q);

    generate
        if (PIPE_MUL != 0) begin : g_pipe
            logic [RES_W-1:0] pp_q;

            // Cleared at accept so step 0 adds nothing from a previous job.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pp_q <= '0;
                end else if (state_q == IDLE && in_valid) begin
                    pp_q <= '0;
                end else if (state_q == CALC) begin
                    pp_q <= pp_shifted;
                end
            end

            assign acc_add = pp_q;
        end else begin : g_comb
            assign acc_add = pp_shifted;
        end
    endgenerate

    assign acc_sum = acc_q + acc_add;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, step counter, accumulator, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            step_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= num1;
                        b_q    <= num2;
                        step_q <= STEP_LL;
                        acc_q  <= '0;
                        if (zero_op) begin
                            result_q <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_q  <= acc_sum;
                    step_q <= step_q + STEP_W'(1);
                    // Result only changes on the transition into DONE.
                    if (step_q == LAST_STEP) begin
                        result_q <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule : mult6bit_seq_ctrl

// File: tb/tb_mult6bit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult6bit_seq_ctrl
// Self-checking bench for mult6bit_seq_ctrl. Expected products come from
// plain integer multiplication; expected latency comes from the cycle
// counts of the handshake protocol.
// -----------------------------------------------------------------------------
module tb_mult6bit_seq_ctrl;

    localparam int PIPE_MUL = 0;
    localparam int MAX_WAIT = 20;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  num1;
    logic [5:0]  num2;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult6bit_seq_ctrl #(
        .PIPE_MUL (PIPE_MUL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clock edges from the accept edge (counted as 1) to the first edge
    // after which out_valid is high.
    function automatic int exp_latency(input logic [5:0] a, input logic [5:0] b);
`ifdef MULT_CTRL_ZERO_SKIP_EN
        if (a == 6'd0 || b == 6'd0) return 1;
`endif
        return 5 + PIPE_MUL;
    endfunction

    // One full transaction: accept, wait for result, optional stall with
    // ignored in_valid pulses, then the output handshake.
    task automatic do_txn(input logic [5:0] a, input logic [5:0] b, input int stall);
        int          lat;
        logic [11:0] exp_res;
        exp_res = 12'(int'(a) * int'(b));

        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num1     = 6'($urandom);
        num2     = 6'($urandom);
        lat      = 1;
        @(negedge clk);
        while (!out_valid && lat <= MAX_WAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            check("out_valid_timeout", out_valid, 1);
            return;
        end
        check("latency", lat, exp_latency(a, b));
        check("result", result, exp_res);
        check("busy_in_done", busy, 1);

        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            num1     = 6'($urandom);
            num2     = 6'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_result", result, exp_res);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
        check("busy_after_hs", busy, 0);
        check("result_retained", result, exp_res);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num1      = '0;
        num2      = '0;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;

        // Directed cases
        do_txn(6'd5,  6'd6,  0);
        do_txn(6'd63, 6'd63, 0);
        do_txn(6'd56, 6'd7,  0);
        do_txn(6'd0,  6'd45, 0);
        do_txn(6'd9,  6'd9,  3);

        // Reset in the middle of CALC (step 2)
        @(negedge clk);
        in_valid = 1'b1;
        num1     = 6'd21;
        num2     = 6'd42;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) seen_valid = 1'b1;
            end
            check("midrst_no_out_valid", seen_valid, 0);
        end
        do_txn(6'd3, 6'd4, 0);

        // Exhaustive sweep with random output stalls
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] idx;
            idx = 12'(i);
            do_txn(idx[11:6], idx[5:0], int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mult6bit_seq_ctrl
